spi_cmd_decoder: RTL and testbench
==================================

# spi_cmd_decoder

Byte-level command decoder downstream of the SPI bridge. It consumes each received byte (`byte_sync`/`data_in`), parses 2-byte write and 3-byte read frames, and drives the PWM register file's write/read port. Read data is returned to the bridge's `data_out` so the master clocks it out.

## Interface
- `ADDR_W`, 6: register address width; equals the command byte's address field.
- `ADDR_MAX`, 6'h0F: highest valid register address. Larger addresses are suppressed.
- `clk`  in  1  system clock; same clock as the SPI bridge.
- `rst`  in  1  asynchronous, active-high reset.
- `cs_n`  in  1  SPI chip select, raw; synchronized internally.
- `byte_sync`  in  1  1-cycle pulse from the bridge: a new byte is on `data_in`.
- `data_in`  in  8  received byte.
- `data_out`  out  8  byte for the bridge to shift out next.
- `reg_addr`  out  ADDR_W  register address.
- `reg_hi`  out  1  selects the high byte of a 16-bit register.
- `wr_en`  out  1  1-cycle write strobe.
- `wr_data`  out  8  write data; valid with `wr_en`.
- `rd_en`  out  1  1-cycle read strobe.
- `rd_data`  in  8  register file read data; valid the cycle after `rd_en`.
- `addr_err`  out  1  sticky flag: an out-of-range address was seen. Cleared only by `rst`.

## Operation
- Command byte fields:
  - bit7 = W (1 write, 0 read)
  - bit6 = `reg_hi`
  - bits5:0 = address
- Write frame: CMD, DATA.
- Read frame: CMD, TURN (dummy), DATA. The master sends 0x00 on the last two bytes. Read data appears on MISO during the third byte.
- FSM states: IDLE, WDATA, RTURN, RDATA. All transitions occur only on `byte_sync` cycles, except the `cs_n` abort.
  - IDLE + byte: latch `reg_addr` and `reg_hi` from the command byte. If W=1, go to WDATA; if W=0, go to RTURN.
  - WDATA + byte: if addr ≤ ADDR_MAX, pulse `wr_en` for one cycle with `wr_data` = `data_in`. Go to IDLE.
  - RTURN + byte: go to RDATA. (`rd_en` was already issued; see Timing.)
  - RDATA + byte: go to IDLE. Clear `data_out` to 0x00 on the following cycle.
- Back-to-back frames within a single `cs_n` assertion are legal. Each new frame starts from IDLE.
- Out-of-range address:
  - Write: no `wr_en`.
  - Read: no `rd_en`, and `data_out` stays 0x00.
  - In both cases `addr_err` is set; the frame length is unchanged.
- Synchronized `cs_n` high (abort or frame end): force IDLE and set `data_out` = 0x00. Any pending `rd_en`/`wr_en` not yet issued is dropped.
- `cs_n` synchronizer: 2 flops, reset to 1 (deasserted).

## Timing
- Reset values:
  - state = IDLE
  - `data_out` = 0x00
  - `reg_addr` = 0, `reg_hi` = 0
  - `wr_en` = 0, `wr_data` = 0x00
  - `rd_en` = 0
  - `addr_err` = 0
  - synchronizer = 2'b11
- Write: `wr_en` asserts in cycle T+1, where T is the DATA-byte `byte_sync` cycle.
- Read:
  - `rd_en` asserts in cycle T+1, where T is the CMD-byte `byte_sync` cycle.
  - `data_out` <= `rd_data` at T+2.
  - `data_out` holds until the RDATA byte completes.
- Bridge constraint: the bridge samples `data_out` in the same cycle it pulses `byte_sync`. Read data loaded after the CMD byte is therefore sampled at the end of TURN and shifted out during DATA. The TURN byte returns 0x00.
- `cs_n` abort: state = IDLE within 3 cycles of `cs_n` rising (2-flop sync plus 1).
- If `byte_sync` and synchronized `cs_n` high coincide, the abort wins and the byte is ignored.
- `byte_sync` pulses are at least 16 `clk` cycles apart (8 SCLK bits at SCLK ≤ clk/2). The decoder needs no back-pressure.

## Structure
- Shared package `pwm_regs_pkg`:
  - command bit positions (CMD_W_BIT = 7, CMD_HI_BIT = 6)
  - ADDR_W
  - ADDR_MAX
  - state enum `cmd_state_t`
- One sub-module: `sync_2ff`, the generic 2-flop synchronizer for `cs_n`, reset value parameterizable.
- Top level: FSM plus output registers.

## Test plan
- Write: CMD 0x83, then 0x5A → one `wr_en` pulse with `reg_addr` = 3, `reg_hi` = 0, `wr_data` = 0x5A; no `rd_en`.
- Read: reg 0x05 hi holds 0xC3. Send CMD 0x45, 0x00, 0x00 → one `rd_en`; bytes returned to master are [0x00, 0x00, 0xC3]; `data_out` = 0x00 after the frame.
- Back-to-back in one `cs_n`: write 0x81/0x11, then write 0x82/0x22 → two `wr_en` pulses, addresses 1 and 2, data 0x11 and 0x22.
- Out of range: CMD 0x90, then 0xFF → no `wr_en`, `addr_err` = 1 and stays 1. A following valid read of addr 0 works normally.
- Abort: CMD 0x84, then `cs_n` high before the data byte → no `wr_en`, state IDLE within 3 cycles. The next frame (0x84, 0x77) writes 0x77 to addr 4.
- Reset mid-read: assert `rst` after the CMD byte → all outputs at reset values immediately. Post-reset frames decode from IDLE.

Source files
------------

// File: rtl/pwm_regs_pkg.sv
// Shared definitions for the PWM register-file command path:
// command byte layout, address range and decoder states.
package pwm_regs_pkg;
  localparam int CMD_W_BIT  = 7;
  localparam int CMD_HI_BIT = 6;
  localparam int ADDR_W     = 6;
  localparam logic [ADDR_W-1:0] ADDR_MAX = 6'h0F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    RTURN = 2'd2,
    RDATA = 2'd3
  } cmd_state_t;
endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with a configurable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] ff_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff_q <= {2{RST_VAL}};
    else     ff_q <= {ff_q[0], d};
  end

  assign q = ff_q[1];
endmodule

// File: rtl/spi_cmd_decoder.sv
// Byte-level SPI command decoder: parses 2-byte write and 3-byte read
// frames and drives the register file port; read data goes back to MISO.
module spi_cmd_decoder
  import pwm_regs_pkg::*;
#(
  parameter int                ADDR_W   = pwm_regs_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] ADDR_MAX = pwm_regs_pkg::ADDR_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              byte_sync,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_hi,
  output logic              wr_en,
  output logic [7:0]        wr_data,
  output logic              rd_en,
  input  logic [7:0]        rd_data,
  output logic              addr_err
);
  cmd_state_t        state_q, state_d;
  logic [7:0]        data_out_q, data_out_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic              reg_hi_q, reg_hi_d;
  logic              wr_en_q, wr_en_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              rd_en_q, rd_en_d;
  logic              rd_ld_q, rd_ld_d;
  logic              addr_err_q, addr_err_d;
  logic              cs_sync;
  logic              cmd_ok, addr_ok;

  sync_2ff #(.RST_VAL(1'b1)) u_cs_sync (
    .clk (clk),
    .rst (rst),
    .d   (cs_n),
    .q   (cs_sync)
  );

  assign cmd_ok  = (data_in[ADDR_W-1:0] <= ADDR_MAX);
  assign addr_ok = (reg_addr_q <= ADDR_MAX);

  always_comb begin
    state_d    = state_q;
    data_out_d = data_out_q;
    reg_addr_d = reg_addr_q;
    reg_hi_d   = reg_hi_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    rd_en_d    = 1'b0;
    rd_ld_d    = 1'b0;
    addr_err_d = addr_err_q;

    // Deselect beats everything, including a coincident byte.
    if (cs_sync) begin
      state_d    = IDLE;
      data_out_d = 8'h00;
    end else begin
      // rd_data is valid the cycle after rd_en; capture it then.
      rd_ld_d = rd_en_q;
      if (rd_ld_q) data_out_d = rd_data;
      if (byte_sync) begin
        unique case (state_q)
          IDLE: begin
            reg_addr_d = data_in[ADDR_W-1:0];
            reg_hi_d   = data_in[CMD_HI_BIT];
            if (!cmd_ok) addr_err_d = 1'b1;
            if (data_in[CMD_W_BIT]) begin
              state_d = WDATA;
            end else begin
              state_d = RTURN;
              rd_en_d = cmd_ok;
            end
          end
          WDATA: begin
            if (addr_ok) begin
              wr_en_d   = 1'b1;
              wr_data_d = data_in;
            end
            state_d = IDLE;
          end
          RTURN: state_d = RDATA;
          RDATA: begin
            state_d    = IDLE;
            data_out_d = 8'h00;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      data_out_q <= 8'h00;
      reg_addr_q <= '0;
      reg_hi_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= 8'h00;
      rd_en_q    <= 1'b0;
      rd_ld_q    <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_out_q <= data_out_d;
      reg_addr_q <= reg_addr_d;
      reg_hi_q   <= reg_hi_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      rd_en_q    <= rd_en_d;
      rd_ld_q    <= rd_ld_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign data_out = data_out_q;
  assign reg_addr = reg_addr_q;
  assign reg_hi   = reg_hi_q;
  assign wr_en    = wr_en_q;
  assign wr_data  = wr_data_q;
  assign rd_en    = rd_en_q;
  assign addr_err = addr_err_q;
endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench for spi_cmd_decoder: directed frames push expected
// register-port strobes; a negedge monitor pops and compares them.
module tb_spi_cmd_decoder;
  import pwm_regs_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_n = 1'b1;
  logic       byte_sync = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic [5:0] reg_addr;
  logic       reg_hi;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data = 8'h00;
  logic       addr_err;

  int checks = 0;
  int errors = 0;

  logic [14:0] wr_q[$];   // {addr, hi, data}
  logic [6:0]  rd_q[$];   // {addr, hi}
  logic [7:0]  mem [0:127];

  spi_cmd_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .cs_n      (cs_n),
    .byte_sync (byte_sync),
    .data_in   (data_in),
    .data_out  (data_out),
    .reg_addr  (reg_addr),
    .reg_hi    (reg_hi),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  // Register file model: registered read, data valid the cycle after rd_en.
  always @(posedge clk) if (rd_en) rd_data <= mem[{reg_addr, reg_hi}];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [14:0] we;
    logic [6:0]  re;
    if (wr_en) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr=%0d hi=%0d data=0x%0h expected no write",
                 reg_addr, reg_hi, wr_data);
      end else begin
        we = wr_q.pop_front();
        if ({reg_addr, reg_hi, wr_data} !== we) begin
          errors++;
          $display("FAIL wr_strobe: got 0x%0h expected 0x%0h", {reg_addr, reg_hi, wr_data}, we);
        end
      end
    end
    if (rd_en) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got addr=%0d hi=%0d expected no read", reg_addr, reg_hi);
      end else begin
        re = rd_q.pop_front();
        if ({reg_addr, reg_hi} !== re) begin
          errors++;
          $display("FAIL rd_strobe: got 0x%0h expected 0x%0h", {reg_addr, reg_hi}, re);
        end
      end
    end
  end

  // Bridge model: data_out is sampled in the byte_sync cycle itself.
  task automatic send_byte(input logic [7:0] b, output logic [7:0] s);
    @(negedge clk);
    data_in   = b;
    byte_sync = 1'b1;
    s         = data_out;
    @(negedge clk);
    byte_sync = 1'b0;
    data_in   = 8'h00;
    repeat (16) @(negedge clk);
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    @(negedge clk);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data_out"}, 32'(data_out), 32'h00);
    chk({tag, "_reg_addr"}, 32'(reg_addr), 32'h00);
    chk({tag, "_reg_hi"},   32'(reg_hi),   32'h0);
    chk({tag, "_wr_en"},    32'(wr_en),    32'h0);
    chk({tag, "_wr_data"},  32'(wr_data),  32'h00);
    chk({tag, "_rd_en"},    32'(rd_en),    32'h0);
    chk({tag, "_addr_err"}, 32'(addr_err), 32'h0);
    chk({tag, "_state"},    32'(dut.state_q), 32'(IDLE));
  endtask

  initial begin
    logic [7:0] s0, s1, s2, s3;
    for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'hA0;
    mem[{6'd5, 1'b1}] = 8'hC3;
    mem[{6'd0, 1'b0}] = 8'h3C;

    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write 0x5A to reg 3 low.
    cs_low();
    wr_q.push_back({6'd3, 1'b0, 8'h5A});
    send_byte(8'h83, s1);
    send_byte(8'h5A, s2);
    chk("wr_miso", 32'({s1, s2}), 32'h0000);
    cs_high();
    chk("wr_addr_err", 32'(addr_err), 32'h0);

    // Read reg 5 high (0xC3).
    cs_low();
    s0 = data_out;
    rd_q.push_back({6'd5, 1'b1});
    send_byte(8'h45, s1);
    send_byte(8'h00, s2);
    send_byte(8'h00, s3);
    chk("rd_first_byte", 32'(s0), 32'h00);
    chk("rd_turn_byte",  32'(s1), 32'h00);
    chk("rd_data_byte",  32'(s2), 32'hC3);
    chk("rd_after_frame", 32'(data_out), 32'h00);
    cs_high();

    // Back-to-back writes in one select.
    cs_low();
    wr_q.push_back({6'd1, 1'b0, 8'h11});
    wr_q.push_back({6'd2, 1'b0, 8'h22});
    send_byte(8'h81, s1);
    send_byte(8'h11, s1);
    send_byte(8'h82, s1);
    send_byte(8'h22, s1);
    cs_high();

    // Out-of-range write (addr 16), then a valid read of addr 0.
    cs_low();
    send_byte(8'h90, s1);
    chk("oor_err_set", 32'(addr_err), 32'h1);
    send_byte(8'hFF, s1);
    rd_q.push_back({6'd0, 1'b0});
    send_byte(8'h00, s1);
    send_byte(8'h00, s2);
    send_byte(8'h00, s3);
    chk("oor_then_rd_data", 32'(s2), 32'h3C);
    // Out-of-range read (addr 16): no strobe, MISO stays zero.
    send_byte(8'h10, s1);
    send_byte(8'h00, s2);
    send_byte(8'h00, s3);
    chk("oor_rd_miso", 32'({s1, s2}), 32'h0000);
    chk("oor_err_sticky", 32'(addr_err), 32'h1);
    cs_high();

    // Abort between CMD and DATA.
    cs_low();
    send_byte(8'h84, s1);
    chk("abort_pre_state", 32'(dut.state_q), 32'(WDATA));
    @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_state_idle", 32'(dut.state_q), 32'(IDLE));
    send_byte(8'h55, s1);
    chk("abort_byte_ignored", 32'(dut.state_q), 32'(IDLE));
    chk("abort_data_out", 32'(data_out), 32'h00);
    cs_low();
    wr_q.push_back({6'd4, 1'b0, 8'h77});
    send_byte(8'h84, s1);
    send_byte(8'h77, s1);
    cs_high();

    // Reset right after a read CMD byte.
    cs_low();
    @(negedge clk);
    data_in   = 8'h45;
    byte_sync = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk_reset_outputs("midrd");
    @(negedge clk);
    byte_sync = 1'b0;
    data_in   = 8'h00;
    rst       = 1'b0;
    repeat (4) @(negedge clk);
    wr_q.push_back({6'd15, 1'b1, 8'hA5});
    send_byte(8'hCF, s1);
    send_byte(8'hA5, s1);
    chk("post_rst_addr_err", 32'(addr_err), 32'h0);
    cs_high();

    repeat (10) @(negedge clk);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
